// File: rtl/mc_controller_pkg.sv
// ---------------------------------------------------------------------------
// mc_controller_pkg
// Shared types for the multi-cycle RV32I controller:
//   - e_mcState  : main FSM states
//   - OP_*       : supported opcodes
//   - e_resultSrc, e_aluSrcA, e_aluSrcB, e_immSrc : datapath select encodings
//   - e_aluOp    : 4-bit ALU operation code
//   - t_ctrl     : bundle of Moore outputs for one state
//   - state_ctrl : maps a state to its Moore outputs
// ---------------------------------------------------------------------------
package mc_controller_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, JAL, BEQ, TRAP
    } e_mcState;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_DATA   = 2'b01,
        RES_ALU    = 2'b10
    } e_resultSrc;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } e_aluSrcA;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } e_aluSrcB;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } e_immSrc;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4
    } e_aluOp;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        e_resultSrc result_src;
        e_aluSrcA   alu_src_a;
        e_aluSrcB   alu_src_b;
        e_aluOp     alu_op;
        logic       illegal;
    } t_ctrl;

    // exec_op is only consulted in EXECR/EXECI; every other state has a fixed op.
    function automatic t_ctrl state_ctrl(input e_mcState s, input e_aluOp exec_op);
        t_ctrl c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALU;
                c.pc_update  = 1'b1;
            end
            DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            MEMREAD:  c.adr_src = 1'b1;
            MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = exec_op;
            end
            EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = exec_op;
            end
            ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            BEQ: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.alu_op     = ALU_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            TRAP:     c.illegal = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// ---------------------------------------------------------------------------
// mc_controller_alu_decoder
// Combinational ALU-operation decode and legality check for the controller.
// Ports:
//   op          in   7  instruction opcode
//   funct3      in   3  instr[14:12]
//   funct7b5    in   1  instr[30]
//   alu_op      out  4  ALU operation for EXECR/EXECI
//   unsupported out  1  high when this core cannot execute the instruction
// ---------------------------------------------------------------------------
module mc_controller_alu_decoder
    import mc_controller_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_op,
    output logic       unsupported
);

    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            // addi shares funct3 000 with add/sub but has no funct7, so only R-type may subtract
            3'b000:  alu_op = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b100:  alu_op = ALU_XOR;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        unsupported = 1'b0;
        case (op)
            OP_LW, OP_SW: unsupported = (funct3 != 3'b010);
            OP_BEQ:       unsupported = (funct3 != 3'b000);
            OP_R, OP_I:   unsupported = !(funct3 inside {3'b000, 3'b100, 3'b110, 3'b111});
            OP_JAL:       unsupported = 1'b0;
            default:      unsupported = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
// Multi-cycle RV32I control unit: main Moore FSM plus ALU-op and immediate
// decode. Drives datapath enables and mux selects.
//
// Optional feature: define MC_CTRL_PERF_CNT_EN to add the cycle and
// instructions-retired counters (width PERF_CNT_W).
//
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   i_op/i_funct3/i_funct7b5     instruction fields, valid from DECODE on
//   i_zeroFlag                   ALU zero flag, used in BEQ
//   o_pcWrite                    PC enable (pcUpdate | branch & zero)
//   o_adrSrc, o_memWrite         memory address select, data write enable
//   o_irWrite, o_regWrite        IR/oldPC enable, register file write enable
//   o_resultSrc, o_aluSrcA/B     result and ALU operand selects
//   o_immSrc                     immediate type, decoded from i_op
//   o_aluLogicOperation          ALU op code
//   o_illegalInstr               sticky, high while in TRAP
//   o_cycleCount/o_instretCount  performance counters (macro only)
// ---------------------------------------------------------------------------
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int PERF_CNT_W = 32
)
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zeroFlag,
    output logic       o_pcWrite,
    output logic       o_adrSrc,
    output logic       o_memWrite,
    output logic       o_irWrite,
    output logic       o_regWrite,
    output logic [1:0] o_resultSrc,
    output logic [1:0] o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [1:0] o_immSrc,
    output logic [3:0] o_aluLogicOperation,
    output logic       o_illegalInstr
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] o_cycleCount,
    output logic [PERF_CNT_W-1:0] o_instretCount
`endif
);

    // state    | meaning
    // FETCH    | read instr at PC, PC <= PC+4
    // DECODE   | classify opcode, compute branch/jump target
    // MEMADR   | rs1 + imm address for lw/sw
    // MEMREAD  | read data memory at ALUOut
    // MEMWB    | write loaded data to rd
    // MEMWRITE | write rs2 to data memory
    // EXECR    | R-type ALU operation
    // EXECI    | I-type ALU operation
    // ALUWB    | write ALUOut to rd
    // JAL      | PC <= target, ALU forms oldPC+4 for rd
    // BEQ      | compare rs1/rs2, take branch on zero
    // TRAP     | unsupported instruction, parked until reset

    e_mcState   state;
    e_mcState   state_n;
    t_ctrl      ctrl_q;
    logic [3:0] dec_alu_op;
    logic       dec_unsupported;

    mc_controller_alu_decoder u_alu_decoder (
        .op          (i_op),
        .funct3      (i_funct3),
        .funct7b5    (i_funct7b5),
        .alu_op      (dec_alu_op),
        .unsupported (dec_unsupported)
    );

    always_comb begin
        state_n = state;
        case (state)
            FETCH:    state_n = DECODE;
            DECODE: begin
                if (dec_unsupported) begin
                    state_n = TRAP;
                end else begin
                    case (i_op)
                        OP_LW, OP_SW: state_n = MEMADR;
                        OP_R:         state_n = EXECR;
                        OP_I:         state_n = EXECI;
                        OP_JAL:       state_n = JAL;
                        OP_BEQ:       state_n = BEQ;
                        default:      state_n = TRAP;
                    endcase
                end
            end
            MEMADR:   state_n = (i_op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_n = MEMWB;
            MEMWB:    state_n = FETCH;
            MEMWRITE: state_n = FETCH;
            EXECR:    state_n = ALUWB;
            EXECI:    state_n = ALUWB;
            ALUWB:    state_n = FETCH;
            JAL:      state_n = ALUWB;
            BEQ:      state_n = FETCH;
            TRAP:     state_n = TRAP;
            default:  state_n = FETCH;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state register; the reset value is the FETCH decode so FETCH outputs
    // are present in the first cycle after reset is released.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= FETCH;
            ctrl_q <= state_ctrl(FETCH, ALU_ADD);
        end else begin
            state  <= state_n;
            ctrl_q <= state_ctrl(state_n, e_aluOp'(dec_alu_op));
        end
    end

    // Enables are gated by reset combinationally so an abort is immediate.
    assign o_pcWrite  = ~i_rst & (ctrl_q.pc_update | (ctrl_q.branch & i_zeroFlag));
    assign o_memWrite = ~i_rst & ctrl_q.mem_write;
    assign o_irWrite  = ~i_rst & ctrl_q.ir_write;
    assign o_regWrite = ~i_rst & ctrl_q.reg_write;

    assign o_adrSrc            = ctrl_q.adr_src;
    assign o_resultSrc         = ctrl_q.result_src;
    assign o_aluSrcA           = ctrl_q.alu_src_a;
    assign o_aluSrcB           = ctrl_q.alu_src_b;
    assign o_aluLogicOperation = ctrl_q.alu_op;
    assign o_illegalInstr      = ctrl_q.illegal;

    always_comb begin
        case (i_op)
            OP_SW:   o_immSrc = IMM_S;
            OP_BEQ:  o_immSrc = IMM_B;
            OP_JAL:  o_immSrc = IMM_J;
            default: o_immSrc = IMM_I;
        endcase
    end

`ifdef MC_CTRL_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] cycle_q;
    logic [PERF_CNT_W-1:0] instret_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + PERF_CNT_W'(1);
            // these states always return to FETCH, so the edge out of them retires
            if (state inside {MEMWB, MEMWRITE, ALUWB, BEQ}) begin
                instret_q <= instret_q + PERF_CNT_W'(1);
            end
        end
    end

    assign o_cycleCount   = cycle_q;
    assign o_instretCount = instret_q;
`endif

endmodule
